seg7_scan_display: RTL and testbench

//  Parametrised multiplexed seven-segment driver; successor to the fixed 8-digit display path.

---
 rtl/seg7_pkg.sv | 60 ++++++
 rtl/seg7_scan_display_bin2bcd.sv | 69 ++++++
 rtl/seg7_scan_display.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed seven-segment display path.
//   - state_t     : controller FSM states
//   - GLYPH_*     : active-high segment patterns {g,f,e,d,c,b,a}
//   - hex_to_seg(): nibble to glyph lookup
//   - add3()      : double-dabble digit correction step
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_A     = 7'h77;
   localparam logic [6:0] GLYPH_B     = 7'h7C;
   localparam logic [6:0] GLYPH_C     = 7'h39;
   localparam logic [6:0] GLYPH_D     = 7'h5E;
   localparam logic [6:0] GLYPH_E     = 7'h79;
   localparam logic [6:0] GLYPH_F     = 7'h71;
   localparam logic [6:0] GLYPH_DASH  = 7'h40;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = GLYPH_0;
         4'h1:    seg = GLYPH_1;
         4'h2:    seg = GLYPH_2;
         4'h3:    seg = GLYPH_3;
         4'h4:    seg = GLYPH_4;
         4'h5:    seg = GLYPH_5;
         4'h6:    seg = GLYPH_6;
         4'h7:    seg = GLYPH_7;
         4'h8:    seg = GLYPH_8;
         4'h9:    seg = GLYPH_9;
         4'hA:    seg = GLYPH_A;
         4'hB:    seg = GLYPH_B;
         4'hC:    seg = GLYPH_C;
         4'hD:    seg = GLYPH_D;
         4'hE:    seg = GLYPH_E;
         default: seg = GLYPH_F;
      endcase
      return seg;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble binary to BCD converter, one bit per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_start    : load i_bin and begin DATA_W iterations
//   i_bin      : binary input value
//   o_done_c   : high during the cycle whose clock edge completes the last iteration
//   o_bcd      : lower DIGITS BCD digits of the result
//   o_ovf      : result needs more than DIGITS digits
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int unsigned DATA_W = 27,
   parameter int unsigned DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [DATA_W-1:0]     i_bin,
   output logic                  o_done_c,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_ovf
);

   // 0.302 > log10(2), so NAT_D always covers 2^DATA_W-1; at least one spare digit flags overflow
   localparam int unsigned NAT_D = (DATA_W * 302) / 1000 + 1;
   localparam int unsigned EXT_D = (NAT_D > DIGITS) ? NAT_D : DIGITS + 1;
   localparam int unsigned BCD_W = 4 * EXT_D;
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic [BCD_W-1:0]  r_bcd;
   logic [BCD_W-1:0]  w_adj;
   logic [DATA_W-1:0] r_bin;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_run;

   // add-3 correction on every digit before the shift
   always_comb begin
      w_adj = r_bcd;
      for (int unsigned d = 0; d < EXT_D; d++) begin
         w_adj[4*d +: 4] = add3(r_bcd[4*d +: 4]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bcd <= '0;
         r_bin <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_bcd <= '0;
         r_bin <= i_bin;
         r_cnt <= CNT_W'(DATA_W);
         r_run <= 1'b1;
      end else if (r_run) begin
         r_bcd <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
         r_bin <= {r_bin[DATA_W-2:0], 1'b0};
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) begin
            r_run <= 1'b0;
         end
      end
   end

   assign o_done_c = r_run && (r_cnt == CNT_W'(1));
   assign o_bcd    = r_bcd[4*DIGITS-1:0];
   assign o_ovf    = |r_bcd[BCD_W-1:4*DIGITS];

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed seven-segment driver with hex/decimal display,
// leading-zero blanking, per-digit decimal points, overflow dash and dead time.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : capture request, honoured only while busy_o=0
//   data_i   : value to display
//   dec_i    : 1 = decimal, 0 = hex
//   lzb_i    : blank leading zeros
//   dp_i     : per-digit decimal point enables
//   busy_o   : conversion/commit in progress
//   ovf_o    : decimal value does not fit DIGITS digits
//   an_o     : digit enables (one-hot when active)
//   seg_o    : segments {g,f,e,d,c,b,a}
//   dp_o     : decimal-point segment
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned DATA_W      = 27,
   parameter int unsigned SCAN_DIV    = 20000,
   parameter int unsigned BLANK_CYC   = 2,
   parameter int unsigned SEG_ACT_LOW = 1,
   parameter int unsigned EN_ACT_LOW  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              dec_i,
   input  logic              lzb_i,
   input  logic [DIGITS-1:0] dp_i,
   output logic              busy_o,
   output logic              ovf_o,
   output logic [DIGITS-1:0] an_o,
   output logic [6:0]        seg_o,
   output logic              dp_o
);

   localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
   localparam int unsigned VAL_W   = 4 * DIGITS;
   localparam logic        SEG_INV = (SEG_ACT_LOW != 0);
   localparam logic        EN_INV  = (EN_ACT_LOW != 0);

   state_t              r_state;
   state_t              w_next_state;
   logic                w_capture;
   logic                w_conv_start;
   logic                w_commit;
   logic                r_busy;

   logic [DATA_W-1:0]   r_cap_data;
   logic                r_cap_dec;
   logic                r_cap_lzb;
   logic [DIGITS-1:0]   r_cap_dp;

   logic [VAL_W-1:0]    r_show_val;
   logic                r_show_lzb;
   logic [DIGITS-1:0]   r_show_dp;
   logic                r_show_ovf;

   logic                w_conv_done_c;
   logic [VAL_W-1:0]    w_bcd;
   logic                w_bcd_ovf;

   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;

   logic [DIGITS-1:0]   w_blank;
   logic                w_run_zero;
   logic [3:0]          w_sel_nib;
   logic                w_sel_blank;
   logic                w_sel_dp;
   logic [DIGITS-1:0]   w_onehot;
   logic [DIGITS-1:0]   w_an_act;
   logic [6:0]          w_seg_act;
   logic                w_dp_act;

   logic [DIGITS-1:0]   r_an;
   logic [6:0]          r_seg;
   logic                r_dp;

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_conv_start),
      .i_bin    (data_i),
      .o_done_c (w_conv_done_c),
      .o_bcd    (w_bcd),
      .o_ovf    (w_bcd_ovf)
   );

   // controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
      end
   end

   // controller next state and strobes
   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_conv_start = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load_i) begin
               w_capture    = 1'b1;
               w_conv_start = dec_i;
               w_next_state = dec_i ? ST_CONV : ST_COMMIT;
            end
         end
         ST_CONV: begin
            if (w_conv_done_c) begin
               w_next_state = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_commit     = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // request capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_data <= '0;
         r_cap_dec  <= 1'b0;
         r_cap_lzb  <= 1'b0;
         r_cap_dp   <= '0;
      end else if (w_capture) begin
         r_cap_data <= data_i;
         r_cap_dec  <= dec_i;
         r_cap_lzb  <= lzb_i;
         r_cap_dp   <= dp_i;
      end
   end

   // shown registers, written together so the display never mixes old and new values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_show_val <= '0;
         r_show_lzb <= 1'b0;
         r_show_dp  <= '0;
         r_show_ovf <= 1'b0;
      end else if (w_commit) begin
         if (r_cap_dec) begin
            r_show_val <= w_bcd;
            r_show_ovf <= w_bcd_ovf;
         end else begin
            r_show_val <= VAL_W'(r_cap_data);
            r_show_ovf <= 1'b0;
         end
         r_show_lzb <= r_cap_lzb;
         r_show_dp  <= r_cap_dp;
      end
   end

   // slot counter and digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // leading-zero blanking: walk down from the top digit while everything above is zero
   always_comb begin
      w_blank    = '0;
      w_run_zero = 1'b1;
      for (int unsigned j = DIGITS; j > 0; j--) begin
         w_run_zero = w_run_zero && (r_show_val[4*(j-1) +: 4] == 4'd0);
         if (j > 1) begin
            w_blank[j-1] = r_show_lzb && w_run_zero && !r_show_ovf;
         end
      end
   end

   // active-high output selection for the current slot
   always_comb begin
      w_sel_nib   = 4'd0;
      w_sel_blank = 1'b0;
      w_sel_dp    = 1'b0;
      w_an_act    = '0;
      w_seg_act   = GLYPH_BLANK;
      w_dp_act    = 1'b0;
      w_onehot    = DIGITS'(1) << r_idx;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_sel_nib   = r_show_val[4*k +: 4];
            w_sel_blank = w_blank[k];
            w_sel_dp    = r_show_dp[k];
         end
      end
      if (r_cnt >= CNT_W'(BLANK_CYC)) begin
         if (r_show_ovf) begin
            w_an_act  = w_onehot;
            w_seg_act = GLYPH_DASH;
         end else if (w_sel_blank) begin
            // a blanked digit stays dark unless its decimal point is requested
            if (w_sel_dp) begin
               w_an_act = w_onehot;
               w_dp_act = 1'b1;
            end
         end else begin
            w_an_act  = w_onehot;
            w_seg_act = hex_to_seg(w_sel_nib);
            w_dp_act  = w_sel_dp;
         end
      end
   end

   // output registers with board polarity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= {DIGITS{EN_INV}};
         r_seg <= {7{SEG_INV}};
         r_dp  <= SEG_INV;
      end else begin
         r_an  <= w_an_act ^ {DIGITS{EN_INV}};
         r_seg <= w_seg_act ^ {7{SEG_INV}};
         r_dp  <= w_dp_act ^ SEG_INV;
      end
   end

   assign busy_o = r_busy;
   assign ovf_o  = r_show_ovf;
   assign an_o   = r_an;
   assign seg_o  = r_seg;
   assign dp_o   = r_dp;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: randomized scoreboard bench for seg7_scan_display.
// Stimulus pushes the expected display for each accepted load (or reset);
// the monitor pops on each commit/reset release and watches one full scan rotation.
module tb_seg7_scan_display;

   localparam int unsigned DIGITS    = 8;
   localparam int unsigned DATA_W    = 27;
   localparam int unsigned SCAN_DIV  = 4;
   localparam int unsigned BLANK_CYC = 1;

   logic              clk    = 1'b0;
   logic              rst    = 1'b1;
   logic              load_i = 1'b0;
   logic [DATA_W-1:0] data_i = '0;
   logic              dec_i  = 1'b0;
   logic              lzb_i  = 1'b0;
   logic [DIGITS-1:0] dp_i   = '0;
   logic              busy_o;
   logic              ovf_o;
   logic [DIGITS-1:0] an_o;
   logic [6:0]        seg_o;
   logic              dp_o;

   always #5 clk = ~clk;

   seg7_scan_display #(
      .DIGITS      (DIGITS),
      .DATA_W      (DATA_W),
      .SCAN_DIV    (SCAN_DIV),
      .BLANK_CYC   (BLANK_CYC),
      .SEG_ACT_LOW (1),
      .EN_ACT_LOW  (1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_i),
      .data_i (data_i),
      .dec_i  (dec_i),
      .lzb_i  (lzb_i),
      .dp_i   (dp_i),
      .busy_o (busy_o),
      .ovf_o  (ovf_o),
      .an_o   (an_o),
      .seg_o  (seg_o),
      .dp_o   (dp_o)
   );

   // expected pin levels per digit (active-low)
   typedef struct packed {
      logic        ovf;
      logic [7:0]  en;
      logic [55:0] seg;
      logic [7:0]  dpo;
   } exp_t;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endtask

   function automatic exp_t model(input longint v, input bit dec, input bit lzb, input logic [7:0] dp);
      exp_t   e;
      longint pw;
      longint above;
      int     dig;
      bit     blank;
      e     = '0;
      pw    = 1;
      e.ovf = dec && (v >= 64'd100000000);
      for (int k = 0; k < 8; k++) begin
         if (dec) begin
            above = v / pw;
            dig   = int'(above % 10);
            pw    = pw * 10;
         end else begin
            above = v >> (4 * k);
            dig   = int'(above & 15);
         end
         blank = lzb && (k > 0) && (above == 0);
         if (e.ovf) begin
            e.en[k]         = 1'b1;
            e.seg[k*7 +: 7] = 7'h3F;
            e.dpo[k]        = 1'b1;
         end else if (blank) begin
            e.en[k]         = dp[k];
            e.seg[k*7 +: 7] = 7'h7F;
            e.dpo[k]        = ~dp[k];
         end else begin
            e.en[k]         = 1'b1;
            e.seg[k*7 +: 7] = ~GLYPH[dig];
            e.dpo[k]        = ~dp[k];
         end
      end
      return e;
   endfunction

   function automatic int next_en(input logic [7:0] en, input int a);
      for (int s = 1; s <= 8; s++) begin
         if (en[(a + s) % 8]) return (a + s) % 8;
      end
      return a;
   endfunction

   // monitor: one scan rotation after every commit or reset release
   initial begin
      logic prev_busy;
      logic prev_rst;
      exp_t e;
      int   cnt [8];
      int   multi, seg_err, dp_err, ord_err, last_k, nact, k;
      logic [7:0] act_v;
      logic [7:0] bad;
      prev_busy = 1'b0;
      prev_rst  = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && ((prev_busy && !busy_o) || prev_rst)) begin
            chk("expect_available", 64'(exp_q.size() > 0), 64'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            @(negedge clk);
            chk("ovf", 64'(ovf_o), 64'(e.ovf));
            multi = 0; seg_err = 0; dp_err = 0; ord_err = 0; last_k = -1;
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            for (int c = 0; c < 8 * int'(SCAN_DIV); c++) begin
               @(negedge clk);
               act_v = ~an_o;
               nact  = $countones(act_v);
               if (nact > 1) multi++;
               else if (nact == 1) begin
                  k = 0;
                  for (int i = 0; i < 8; i++) if (act_v[i]) k = i;
                  cnt[k]++;
                  if (seg_o !== e.seg[k*7 +: 7]) seg_err++;
                  if (dp_o !== e.dpo[k]) dp_err++;
                  if (last_k >= 0 && k != last_k && k != next_en(e.en, last_k)) ord_err++;
                  last_k = k;
               end
            end
            for (int i = 0; i < 8; i++)
               bad[i] = (cnt[i] != (e.en[i] ? int'(SCAN_DIV - BLANK_CYC) : 0));
            chk("onehot_violations", 64'(multi), 64'd0);
            chk("seg_mismatch_cycles", 64'(seg_err), 64'd0);
            chk("dp_mismatch_cycles", 64'(dp_err), 64'd0);
            chk("scan_order_errors", 64'(ord_err), 64'd0);
            chk("dwell_bad_digit_mask", 64'(bad), 64'd0);
         end
         prev_busy = busy_o;
         prev_rst  = rst;
      end
   end

   task automatic do_load(input longint v, input bit dec, input bit lzb, input logic [7:0] dp,
                          input int inject, output int bcnt);
      @(posedge clk); #2;
      load_i = 1'b1; data_i = DATA_W'(v); dec_i = dec; lzb_i = lzb; dp_i = dp;
      exp_q.push_back(model(v, dec, lzb, dp));
      @(posedge clk); #2;
      load_i = 1'b0; data_i = DATA_W'($urandom); dec_i = 1'($urandom);
      lzb_i = 1'($urandom); dp_i = 8'($urandom);
      bcnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         load_i = 1'b0;
         if (!busy_o) break;
         bcnt++;
         if (bcnt == inject) begin
            load_i = 1'b1; data_i = DATA_W'(999); dec_i = 1'b0;
         end
      end
      load_i = 1'b0;
   endtask

   task automatic reset_pulse();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_an", 64'(an_o), 64'hFF);
      chk("rst_seg", 64'(seg_o), 64'h7F);
      chk("rst_dp", 64'(dp_o), 64'd1);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_ovf", 64'(ovf_o), 64'd0);
      exp_q.push_back(model(0, 1'b0, 1'b0, 8'h00));
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   // stimulus
   initial begin
      int     bc;
      bit     d, l;
      longint v;
      exp_q.push_back(model(0, 1'b0, 1'b0, 8'h00));
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);

      do_load(64'h51, 1'b0, 1'b1, 8'h00, 0, bc);
      chk("busy_len_hex51", 64'(bc), 64'd1);
      repeat (40) @(negedge clk);

      repeat (5) @(negedge clk);
      reset_pulse();

      do_load(567, 1'b1, 1'b0, 8'h02, 0, bc);
      chk("busy_len_dec567", 64'(bc), 64'd28);
      repeat (40) @(negedge clk);

      do_load(100000000, 1'b1, 1'b1, 8'hFF, 0, bc);
      chk("busy_len_ovf", 64'(bc), 64'd28);
      repeat (40) @(negedge clk);
      do_load(5, 1'b1, 1'b0, 8'h00, 0, bc);
      repeat (40) @(negedge clk);

      do_load(1234, 1'b1, 1'b1, 8'h10, 5, bc);
      chk("busy_len_conv_inject", 64'(bc), 64'd28);
      repeat (40) @(negedge clk);

      do_load(64'hABC, 1'b0, 1'b0, 8'h81, 1, bc);
      chk("busy_len_commit_inject", 64'(bc), 64'd1);
      repeat (40) @(negedge clk);

      // abort a conversion with reset
      @(posedge clk); #2;
      load_i = 1'b1; data_i = DATA_W'(4321); dec_i = 1'b1; lzb_i = 1'b0; dp_i = 8'h00;
      exp_q.push_back(model(4321, 1'b1, 1'b0, 8'h00));
      @(posedge clk); #2 load_i = 1'b0;
      repeat (10) @(negedge clk);
      void'(exp_q.pop_back());
      reset_pulse();

      for (int i = 0; i < 12; i++) begin
         d = 1'($urandom);
         l = 1'($urandom);
         case ($urandom_range(0, 2))
            0:       v = longint'($urandom & 32'h07FF_FFFF);
            1:       v = longint'($urandom_range(0, 99999));
            default: v = longint'($urandom_range(0, 255));
         endcase
         do_load(v, d, l, 8'($urandom), 0, bc);
         chk("busy_len_random", 64'(bc), d ? 64'd28 : 64'd1);
         repeat (40) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
